// File: rtl/pspin_cfg_pkg.sv
// Command-interface types shared by the HPU command unit and its responders.
package pspin_cfg_pkg;

    typedef logic [1:0] pspin_cmd_intf_id_t;
    typedef logic [1:0] pspin_cmd_type_t;

    localparam pspin_cmd_intf_id_t CMD_NIC_OUTBOUND_ID = 2'd1;

    typedef struct packed {
        logic [7:0] cluster_id;
        logic [3:0] core_id;
        logic [3:0] local_cmd_id;
    } pspin_cmd_id_t;

    typedef struct packed {
        logic [31:0] nid;
        logic [31:0] fid;
        logic [31:0] src_addr;
        logic [31:0] length;
    } nic_cmd_t;

    typedef struct packed {
        nic_cmd_t nic_cmd;
    } pspin_cmd_descr_t;

    typedef struct packed {
        pspin_cmd_id_t      cmd_id;
        pspin_cmd_type_t    cmd_type;
        pspin_cmd_intf_id_t intf_id;
        logic               to_uncluster;
        pspin_cmd_descr_t   descr;
    } pspin_cmd_req_t;

    typedef struct packed {
        pspin_cmd_id_t cmd_id;
    } pspin_cmd_resp_t;

endpackage

// File: rtl/nic_cmd_responder.sv
// NIC-outbound command responder: forwards nic_cmd_t to the NIC engine and
// returns cmd_id responses in issue order as in-order completions arrive.
module nic_cmd_responder
    import pspin_cfg_pkg::*;
#(
    parameter int unsigned        NUM_OUTSTANDING = 8,
    parameter pspin_cmd_intf_id_t NIC_INTF_ID     = CMD_NIC_OUTBOUND_ID
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               cmd_req_valid_i,
    output logic                               cmd_req_ready_o,
    input  pspin_cmd_req_t                     cmd_req_i,
    output logic                               nic_cmd_valid_o,
    input  logic                               nic_cmd_ready_i,
    output nic_cmd_t                           nic_cmd_o,
    input  logic                               nic_cmd_done_i,
    output logic                               cmd_resp_valid_o,
    input  logic                               cmd_resp_ready_i,
    output pspin_cmd_resp_t                    cmd_resp_o,
    output logic [$clog2(NUM_OUTSTANDING):0]   outstanding_o,
    output logic                               err_bad_intf_o,
    output logic                               err_spurious_done_o
);

    localparam int unsigned PTR_W = $clog2(NUM_OUTSTANDING);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t FULL_CNT = cnt_t'(NUM_OUTSTANDING);

    function automatic cnt_t step_cnt(input cnt_t cnt, input logic inc, input logic dec);
        cnt_t res;
        res = cnt;
        if (inc && !dec) begin
            res = cnt + cnt_t'(1);
        end else if (dec && !inc) begin
            res = cnt - cnt_t'(1);
        end
        return res;
    endfunction

    pspin_cmd_id_t fifo_mem [NUM_OUTSTANDING];
    ptr_t          wr_ptr;
    ptr_t          rd_ptr;
    cnt_t          occ;
    cnt_t          at_nic;
    cnt_t          done_cnt;

    nic_cmd_t      nic_cmd_p1;
    logic          nic_vld_p1;
    logic          err_bad_p1;
    logic          err_spur_p1;

    logic          fifo_full;
    logic          req_hs;
    logic          intf_ok;
    logic          push;
    logic          pop;
    logic          nic_hs;
    logic          done_ok;
    logic          resp_vld;

    // cmd_type and to_uncluster carry no meaning for the NIC path
    logic          unused_req_fields;
    assign unused_req_fields = ^{cmd_req_i.cmd_type, cmd_req_i.to_uncluster};

    assign fifo_full       = (occ == FULL_CNT);
    assign cmd_req_ready_o = !fifo_full && (!nic_vld_p1 || nic_cmd_ready_i);

    assign req_hs  = cmd_req_valid_i && cmd_req_ready_o;
    assign intf_ok = (cmd_req_i.intf_id == NIC_INTF_ID);
    assign push    = req_hs && intf_ok;
    assign nic_hs  = nic_vld_p1 && nic_cmd_ready_i;
    assign done_ok = nic_cmd_done_i && (at_nic != '0);
    assign resp_vld = (done_cnt != '0);
    assign pop     = resp_vld && cmd_resp_ready_i;

    // Stage p0 -> p1: request accept, NIC slot, tracking counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            at_nic      <= '0;
            done_cnt    <= '0;
            nic_vld_p1  <= 1'b0;
            nic_cmd_p1  <= '0;
            err_bad_p1  <= 1'b0;
            err_spur_p1 <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            occ      <= step_cnt(occ, push, pop);
            at_nic   <= step_cnt(at_nic, nic_hs, done_ok);
            done_cnt <= step_cnt(done_cnt, done_ok, pop);

            if (push) begin
                nic_vld_p1 <= 1'b1;
                nic_cmd_p1 <= cmd_req_i.descr.nic_cmd;
            end else if (nic_hs) begin
                nic_vld_p1 <= 1'b0;
            end

            err_bad_p1  <= req_hs && !intf_ok;
            // a NIC handshake in the same cycle cannot be completed yet
            err_spur_p1 <= nic_cmd_done_i && (at_nic == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_req_i.cmd_id;
        end
    end

    always_comb begin
        cmd_resp_o = '0;
        if (resp_vld) begin
            cmd_resp_o.cmd_id = fifo_mem[rd_ptr];
        end
    end

    assign cmd_resp_valid_o    = resp_vld;
    assign nic_cmd_valid_o     = nic_vld_p1;
    assign nic_cmd_o           = nic_cmd_p1;
    assign outstanding_o       = occ;
    assign err_bad_intf_o      = err_bad_p1;
    assign err_spurious_done_o = err_spur_p1;

endmodule

// File: tb/tb_nic_cmd_responder.sv
// Directed and randomized bench for nic_cmd_responder with a cycle model and cmd_id scoreboard.
module tb_nic_cmd_responder;
    import pspin_cfg_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            cmd_req_valid;
    logic            cmd_req_ready;
    pspin_cmd_req_t  cmd_req;
    logic            nic_cmd_valid;
    logic            nic_cmd_ready;
    nic_cmd_t        nic_cmd;
    logic            nic_cmd_done;
    logic            cmd_resp_valid;
    logic            cmd_resp_ready;
    pspin_cmd_resp_t cmd_resp;
    logic [3:0]      outstanding;
    logic            err_bad_intf;
    logic            err_spurious_done;

    nic_cmd_responder #(.NUM_OUTSTANDING(8), .NIC_INTF_ID(2'd1)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .cmd_req_valid_i     (cmd_req_valid),
        .cmd_req_ready_o     (cmd_req_ready),
        .cmd_req_i           (cmd_req),
        .nic_cmd_valid_o     (nic_cmd_valid),
        .nic_cmd_ready_i     (nic_cmd_ready),
        .nic_cmd_o           (nic_cmd),
        .nic_cmd_done_i      (nic_cmd_done),
        .cmd_resp_valid_o    (cmd_resp_valid),
        .cmd_resp_ready_i    (cmd_resp_ready),
        .cmd_resp_o          (cmd_resp),
        .outstanding_o       (outstanding),
        .err_bad_intf_o      (err_bad_intf),
        .err_spurious_done_o (err_spurious_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $fatal(1, "FAIL watchdog: simulation did not finish in time");
    end

    int            n_chk;
    int            n_fail;
    int            m_at_nic;
    int            m_done;
    bit            m_nic_vld;
    nic_cmd_t      m_nic_cmd;
    bit            m_err_bad;
    bit            m_err_spur;
    pspin_cmd_id_t sb_q[$];
    bit            acc;
    int            n_resp;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic pspin_cmd_req_t mk_req(input logic [7:0] cl, input logic [3:0] co,
                                              input logic [3:0] lo, input pspin_cmd_intf_id_t intf,
                                              input logic [31:0] nid, input logic [31:0] len);
        pspin_cmd_req_t r;
        r = '0;
        r.cmd_id.cluster_id      = cl;
        r.cmd_id.core_id         = co;
        r.cmd_id.local_cmd_id    = lo;
        r.cmd_type               = 2'd3;
        r.intf_id                = intf;
        r.to_uncluster           = 1'b1;
        r.descr.nic_cmd.nid      = nid;
        r.descr.nic_cmd.fid      = nid ^ 32'h5A5A_1234;
        r.descr.nic_cmd.src_addr = {nid[15:0], len[15:0]};
        r.descr.nic_cmd.length   = len;
        return r;
    endfunction

    // Called at a negedge with this cycle's inputs applied; returns at the next negedge.
    task automatic tick();
        bit m_ready;
        bit req_hs;
        bit nic_hs;
        bit done_ok;
        bit resp_hs;
        #1;
        if (!rst_n) begin
            m_at_nic   = 0;
            m_done     = 0;
            m_nic_vld  = 1'b0;
            m_err_bad  = 1'b0;
            m_err_spur = 1'b0;
            sb_q.delete();
        end
        m_ready = (sb_q.size() < 8) && (!m_nic_vld || nic_cmd_ready);
        chk("req_ready", 128'(cmd_req_ready), 128'(m_ready));
        chk("nic_valid", 128'(nic_cmd_valid), 128'(m_nic_vld));
        if (m_nic_vld) chk("nic_cmd", 128'(nic_cmd), 128'(m_nic_cmd));
        chk("resp_valid", 128'(cmd_resp_valid), 128'(m_done != 0));
        if (m_done != 0) chk("resp_id", 128'(cmd_resp.cmd_id), 128'(sb_q[0]));
        chk("outstanding", 128'(outstanding), 128'(sb_q.size()));
        chk("err_bad_intf", 128'(err_bad_intf), 128'(m_err_bad));
        chk("err_spurious", 128'(err_spurious_done), 128'(m_err_spur));
        if (!rst_n) begin
            chk("rst_nic_cmd", 128'(nic_cmd), 128'(0));
            chk("rst_resp", 128'(cmd_resp), 128'(0));
        end
        acc = 1'b0;
        if (rst_n) begin
            req_hs  = cmd_req_valid && m_ready;
            nic_hs  = m_nic_vld && nic_cmd_ready;
            done_ok = nic_cmd_done && (m_at_nic > 0);
            resp_hs = (m_done != 0) && cmd_resp_ready;
            m_err_bad  = req_hs && (cmd_req.intf_id != 2'd1);
            m_err_spur = nic_cmd_done && (m_at_nic == 0);
            if (resp_hs) begin
                void'(sb_q.pop_front());
                n_resp++;
            end
            if (req_hs && cmd_req.intf_id == 2'd1) begin
                sb_q.push_back(cmd_req.cmd_id);
                acc = 1'b1;
            end
            m_at_nic = m_at_nic + int'(nic_hs) - int'(done_ok);
            m_done   = m_done + int'(done_ok) - int'(resp_hs);
            if (req_hs && cmd_req.intf_id == 2'd1) begin
                m_nic_vld = 1'b1;
                m_nic_cmd = cmd_req.descr.nic_cmd;
            end else if (nic_hs) begin
                m_nic_vld = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_acc(input string tag, input int budget);
        acc = 1'b0;
        for (int i = 0; i < budget && !acc; i++) tick();
        chk(tag, 128'(acc), 128'(1));
    endtask

    task automatic drain();
        cmd_req_valid = 1'b0;
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) begin
            nic_cmd_ready  = 1'b1;
            cmd_resp_ready = 1'b1;
            nic_cmd_done   = (m_at_nic > 0);
            tick();
        end
        nic_cmd_done   = 1'b0;
        cmd_resp_ready = 1'b0;
        nic_cmd_ready  = 1'b0;
        chk("drain_empty", 128'(sb_q.size()), 128'(0));
        tick();
    endtask

    initial begin
        pspin_cmd_req_t req_b;
        int issued;
        n_chk = 0; n_fail = 0; n_resp = 0;
        m_at_nic = 0; m_done = 0; m_nic_vld = 1'b0; m_nic_cmd = '0;
        m_err_bad = 1'b0; m_err_spur = 1'b0; acc = 1'b0;
        rst_n = 1'b0; cmd_req_valid = 1'b0; cmd_req = '0;
        nic_cmd_ready = 1'b0; nic_cmd_done = 1'b0; cmd_resp_ready = 1'b0;

        @(negedge clk);
        tick();
        tick();
        chk("reset_outstanding", 128'(outstanding), 128'(0));
        chk("reset_resp_valid", 128'(cmd_resp_valid), 128'(0));
        rst_n = 1'b1;
        tick();

        // single command
        cmd_req = mk_req(8'd2, 4'd5, 4'd1, 2'd1, 32'h0A00_0001, 32'd64);
        cmd_req_valid = 1'b1;
        tick();
        cmd_req_valid = 1'b0;
        chk("t1_nic_valid", 128'(nic_cmd_valid), 128'(1));
        chk("t1_nid", 128'(nic_cmd.nid), 128'(32'h0A00_0001));
        chk("t1_len", 128'(nic_cmd.length), 128'(32'd64));
        chk("t1_occ1", 128'(outstanding), 128'(1));
        nic_cmd_ready = 1'b1;
        tick();
        nic_cmd_ready = 1'b0;
        nic_cmd_done  = 1'b1;
        tick();
        nic_cmd_done  = 1'b0;
        chk("t1_resp_valid", 128'(cmd_resp_valid), 128'(1));
        chk("t1_resp_id", 128'(cmd_resp.cmd_id), 128'({8'd2, 4'd5, 4'd1}));
        cmd_resp_ready = 1'b1;
        tick();
        cmd_resp_ready = 1'b0;
        chk("t1_occ0", 128'(outstanding), 128'(0));
        tick();

        // fill to capacity, then a stalled ninth request
        nic_cmd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cmd_req = mk_req(8'd1, 4'(i), 4'(15 - i), 2'd1, 32'h100 + i, 32'd128);
            cmd_req_valid = 1'b1;
            tick();
            chk("fill_acc", 128'(acc), 128'(1));
        end
        cmd_req = mk_req(8'd9, 4'd9, 4'd9, 2'd1, 32'h999, 32'd256);
        tick();
        tick();
        chk("fill_occ8", 128'(outstanding), 128'(8));
        chk("fill_ready0", 128'(cmd_req_ready), 128'(0));
        chk("fill_stall", 128'(acc), 128'(0));
        nic_cmd_done = 1'b1;
        tick();
        nic_cmd_done = 1'b0;
        tick();
        chk("fill_resp_valid", 128'(cmd_resp_valid), 128'(1));
        chk("fill_still_stalled", 128'(acc), 128'(0));
        cmd_resp_ready = 1'b1;
        tick();
        chk("fill_no_passthru", 128'(acc), 128'(0));
        cmd_resp_ready = 1'b0;
        wait_acc("fill_9th_accept", 4);
        cmd_req_valid = 1'b0;
        drain();

        // NIC backpressure
        nic_cmd_ready = 1'b0;
        cmd_req = mk_req(8'd4, 4'd1, 4'd2, 2'd1, 32'hAAAA_0001, 32'd32);
        cmd_req_valid = 1'b1;
        tick();
        chk("bp_first_acc", 128'(acc), 128'(1));
        req_b = mk_req(8'd4, 4'd1, 4'd3, 2'd1, 32'hBBBB_0002, 32'd48);
        cmd_req = req_b;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_ready0", 128'(cmd_req_ready), 128'(0));
            chk("bp_nid_stable", 128'(nic_cmd.nid), 128'(32'hAAAA_0001));
        end
        nic_cmd_ready = 1'b1;
        tick();
        chk("bp_second_acc", 128'(acc), 128'(1));
        cmd_req_valid = 1'b0;
        nic_cmd_ready = 1'b0;
        chk("bp_second_nid", 128'(nic_cmd.nid), 128'(32'hBBBB_0002));
        drain();

        // bad intf_id and spurious done
        cmd_req = mk_req(8'd7, 4'd7, 4'd7, 2'd2, 32'hDEAD_0000, 32'd8);
        cmd_req_valid = 1'b1;
        tick();
        cmd_req_valid = 1'b0;
        chk("bad_intf_pulse", 128'(err_bad_intf), 128'(1));
        chk("bad_intf_occ", 128'(outstanding), 128'(0));
        chk("bad_intf_nic_valid", 128'(nic_cmd_valid), 128'(0));
        tick();
        chk("bad_intf_once", 128'(err_bad_intf), 128'(0));
        nic_cmd_done = 1'b1;
        tick();
        nic_cmd_done = 1'b0;
        chk("spur_pulse", 128'(err_spurious_done), 128'(1));
        chk("spur_no_resp", 128'(cmd_resp_valid), 128'(0));
        tick();
        chk("spur_once", 128'(err_spurious_done), 128'(0));
        chk("spur_no_resp2", 128'(cmd_resp_valid), 128'(0));

        // reset with commands in flight
        nic_cmd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_req = mk_req(8'd5, 4'(i), 4'd0, 2'd1, 32'h5000 + i, 32'd16);
            cmd_req_valid = 1'b1;
            tick();
        end
        cmd_req_valid = 1'b0;
        tick();
        nic_cmd_ready = 1'b0;
        chk("rst_pre_occ3", 128'(outstanding), 128'(3));
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_occ0", 128'(outstanding), 128'(0));
        chk("rst_nic_valid0", 128'(nic_cmd_valid), 128'(0));
        chk("rst_resp_valid0", 128'(cmd_resp_valid), 128'(0));
        rst_n = 1'b1;
        tick();
        nic_cmd_done = 1'b1;
        tick();
        nic_cmd_done = 1'b0;
        chk("rst_late_done_spur", 128'(err_spurious_done), 128'(1));
        chk("rst_late_done_no_resp", 128'(cmd_resp_valid), 128'(0));
        tick();

        // random backpressure, 20 commands across pointer wrap
        issued = 0;
        n_resp = 0;
        for (int cyc = 0; cyc < 2000 && !(issued == 20 && sb_q.size() == 0); cyc++) begin
            cmd_req_valid  = (issued < 20);
            cmd_req        = mk_req(8'(32 + issued), 4'(issued), 4'(issued >> 4), 2'd1,
                                    32'hC0DE_0000 + issued, 32'(64 + issued));
            nic_cmd_ready  = 1'($urandom_range(0, 1));
            cmd_resp_ready = 1'($urandom_range(0, 1));
            nic_cmd_done   = (m_at_nic > 0) && ($urandom_range(0, 2) == 0);
            tick();
            if (acc) issued++;
        end
        cmd_req_valid = 1'b0; nic_cmd_ready = 1'b0; cmd_resp_ready = 1'b0; nic_cmd_done = 1'b0;
        chk("rand_issued", 128'(issued), 128'(20));
        chk("rand_resp_count", 128'(n_resp), 128'(20));
        chk("rand_empty", 128'(outstanding), 128'(0));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
